// File: rtl/stack_cpu_pkg.sv
// stack_cpu_pkg: shared constants for the stack CPU.
//   - opcode constants (instruction bits [15:12])
//   - ALU function constants (ir[11:9]) and unary sub-codes (ir[8:6])
//   - state_t: FSM state encoding
//   - decode(): maps a fetched opcode to its execute state
package stack_cpu_pkg;

  localparam logic [3:0] OP_LDI  = 4'h1;
  localparam logic [3:0] OP_LD   = 4'h2;
  localparam logic [3:0] OP_ST   = 4'h3;
  localparam logic [3:0] OP_JZ   = 4'h4;
  localparam logic [3:0] OP_JMP  = 4'h5;
  localparam logic [3:0] OP_ALU  = 4'h7;
  localparam logic [3:0] OP_PUSH = 4'h8;
  localparam logic [3:0] OP_POP  = 4'h9;
  localparam logic [3:0] OP_CALL = 4'hA;
  localparam logic [3:0] OP_RET  = 4'hB;

  localparam logic [2:0] ALU_ADD   = 3'd0;
  localparam logic [2:0] ALU_SUB   = 3'd1;
  localparam logic [2:0] ALU_AND   = 3'd2;
  localparam logic [2:0] ALU_OR    = 3'd3;
  localparam logic [2:0] ALU_XOR   = 3'd4;
  localparam logic [2:0] ALU_UNARY = 3'd7;

  // Unary sub-codes share the A-select field ir[8:6].
  localparam logic [2:0] UN_NOT = 3'd0;
  localparam logic [2:0] UN_MOV = 3'd1;
  localparam logic [2:0] UN_INC = 3'd2;
  localparam logic [2:0] UN_DEC = 3'd3;

  typedef enum logic [3:0] {
    S_FETCH, S_LDI, S_LD, S_ST, S_JZ, S_JMP, S_ALU,
    S_PUSH, S_POP, S_CALL, S_RET, S_HALT
  } state_t;

  // Undefined opcodes decode to FETCH, so they behave as one-cycle NOPs.
  function automatic state_t decode(input logic [3:0] op);
    case (op)
      OP_LDI:  decode = S_LDI;
      OP_LD:   decode = S_LD;
      OP_ST:   decode = S_ST;
      OP_JZ:   decode = S_JZ;
      OP_JMP:  decode = S_JMP;
      OP_ALU:  decode = S_ALU;
      OP_PUSH: decode = S_PUSH;
      OP_POP:  decode = S_POP;
      OP_CALL: decode = S_CALL;
      OP_RET:  decode = S_RET;
      default: decode = S_FETCH;
    endcase
  endfunction

endpackage

// File: rtl/stack_cpu_if.sv
// stack_cpu_if: single-port memory bus between the CPU and the memory model.
//   address  : word address driven by the CPU
//   data_out : CPU write data
//   memwt    : write enable, active high
//   data_in  : read data, combinational from address
// Modports: master (CPU side), slave (memory side).
interface stack_cpu_if #(
  parameter int DATA_W = 16,
  parameter int ADDR_W = 12
);
  logic [ADDR_W-1:0] address;
  logic [DATA_W-1:0] data_out;
  logic [DATA_W-1:0] data_in;
  logic              memwt;

  modport master (output address, output data_out, output memwt, input data_in);
  modport slave  (input address, input data_out, input memwt, output data_in);
endinterface

// File: rtl/stack_cpu_alu.sv
// stack_cpu_alu: combinational ALU.
//   a, b   : operands r[ir[8:6]], r[ir[5:3]]
//   fn     : ir[11:6]; [5:3] selects the function, [2:0] the unary sub-op
//   result : modulo 2^DATA_W result, no carry
//   zero   : result == 0
module stack_cpu_alu
  import stack_cpu_pkg::*;
#(
  parameter int DATA_W = 16
) (
  input  logic [DATA_W-1:0] a,
  input  logic [DATA_W-1:0] b,
  input  logic [5:0]        fn,
  output logic [DATA_W-1:0] result,
  output logic              zero
);

  always_comb begin
    result = '0;
    case (fn[5:3])
      ALU_ADD: result = a + b;
      ALU_SUB: result = a - b;
      ALU_AND: result = a & b;
      ALU_OR:  result = a | b;
      ALU_XOR: result = a ^ b;
      ALU_UNARY: begin
        case (fn[2:0])
          UN_NOT:  result = ~b;
          UN_MOV:  result = b;
          UN_INC:  result = b + DATA_W'(1);
          UN_DEC:  result = b - DATA_W'(1);
          default: result = '0;
        endcase
      end
      default: result = '0;
    endcase
  end

  assign zero = (result == '0);

endmodule

// File: rtl/stack_cpu.sv
// stack_cpu: multicycle fetch/execute CPU with a downward-growing stack.
// Every instruction is one FETCH cycle plus one execute cycle; undefined
// opcodes return straight to FETCH.
// Ports:
//   clk    : clock, rising edge
//   rst_n  : asynchronous active-low reset
//   bus    : stack_cpu_if.master (address, data_out, memwt out; data_in in)
//   fault  : sticky stack fault
// Optional feature: define STACK_CHECK_EN to trap stack overflow (PUSH/CALL
// at SP_LIMIT) and underflow (POP/RET at SP_INIT) into a HALT state. When
// undefined, sp wraps silently and fault is tied low.
module stack_cpu
  import stack_cpu_pkg::*;
#(
  parameter int                DATA_W   = 16,
  parameter int                ADDR_W   = 12,
  parameter logic [ADDR_W-1:0] SP_INIT  = '1,
  parameter logic [ADDR_W-1:0] SP_LIMIT = ADDR_W'('h800)
) (
  input  logic        clk,
  input  logic        rst_n,
  stack_cpu_if.master bus,
  output logic        fault
);

  if (DATA_W < 16 || ADDR_W > 12 || SP_LIMIT >= SP_INIT) begin : g_param_err
    $error("stack_cpu: unsupported DATA_W/ADDR_W/SP_LIMIT combination");
  end

  state_t                   state;
  logic [ADDR_W-1:0]        pc, sp;
  logic [11:0]              ir;
  logic                     z;
  logic [7:0][DATA_W-1:0]   regs;

  logic [DATA_W-1:0]        op_a, op_b, alu_res;
  logic                     alu_zero;
  logic [2:0]               dst;
  logic [ADDR_W-1:0]        off, ld_addr, sp_dec, pc_inc;
  logic [ADDR_W-1:0]        addr_c;
  logic [DATA_W-1:0]        dout_c;
  logic                     we_c, stk_err;

  assign op_a    = regs[ir[8:6]];
  assign op_b    = regs[ir[5:3]];
  assign dst     = ir[2:0];
  // ADDR_W <= 12, so truncating ir keeps the two's-complement offset intact
  // modulo 2^ADDR_W.
  assign off     = ir[ADDR_W-1:0];
  assign ld_addr = op_b[ADDR_W-1:0];
  assign sp_dec  = sp - ADDR_W'(1);
  assign pc_inc  = pc + ADDR_W'(1);

  stack_cpu_alu #(.DATA_W(DATA_W)) u_alu (
    .a      (op_a),
    .b      (op_b),
    .fn     (ir[11:6]),
    .result (alu_res),
    .zero   (alu_zero)
  );

`ifdef STACK_CHECK_EN
  logic fault_q;
  assign stk_err = ((state == S_PUSH || state == S_CALL) && sp == SP_LIMIT) ||
                   ((state == S_POP  || state == S_RET)  && sp == SP_INIT);
  assign fault   = fault_q;
`else
  assign stk_err = 1'b0;
  assign fault   = 1'b0;
`endif

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= S_FETCH;
      pc    <= '0;
      ir    <= '0;
      sp    <= SP_INIT;
      z     <= 1'b0;
      regs  <= '0;
`ifdef STACK_CHECK_EN
      fault_q <= 1'b0;
`endif
    end
`ifdef STACK_CHECK_EN
    // A faulting stack op commits nothing; HALT is left only by reset.
    else if (stk_err || state == S_HALT) begin
      state   <= S_HALT;
      fault_q <= 1'b1;
    end
`endif
    else begin
      state <= S_FETCH;
      case (state)
        S_FETCH: begin
          ir    <= bus.data_in[11:0];
          pc    <= pc_inc;
          state <= decode(bus.data_in[15:12]);
        end
        S_LDI: begin
          regs[dst] <= bus.data_in;
          pc        <= pc_inc;
        end
        S_LD:  regs[dst] <= bus.data_in;
        S_JZ:  if (z) pc <= pc + off;
        S_JMP: pc <= pc + off;
        S_ALU: begin
          regs[dst] <= alu_res;
          z         <= alu_zero;
        end
        S_PUSH: sp <= sp_dec;
        S_POP: begin
          regs[dst] <= bus.data_in;
          sp        <= sp + ADDR_W'(1);
        end
        S_CALL: begin
          sp <= sp_dec;
          pc <= pc + off;
        end
        S_RET: begin
          pc <= bus.data_in[ADDR_W-1:0];
          sp <= sp + ADDR_W'(1);
        end
        default: ;
      endcase
    end
  end

  // Bus outputs are combinational from state so reads and writes complete
  // inside the execute cycle.
  always_comb begin
    addr_c = pc;
    we_c   = 1'b0;
    dout_c = op_a;
    case (state)
      S_LD: addr_c = ld_addr;
      S_ST: begin
        addr_c = ld_addr;
        we_c   = 1'b1;
      end
      S_PUSH: begin
        addr_c = sp_dec;
        we_c   = 1'b1;
      end
      S_CALL: begin
        addr_c = sp_dec;
        we_c   = 1'b1;
        dout_c = DATA_W'(pc);
      end
      S_POP, S_RET: addr_c = sp;
      default: ;
    endcase
  end

  assign bus.address  = addr_c;
  assign bus.data_out = dout_c;
  // Gating with rst_n aborts an in-flight write the moment reset asserts.
  assign bus.memwt    = we_c & rst_n & ~stk_err;

endmodule
